disk_xfer_seq: RTL and testbench
================================

DISK_XFER_SEQ -- requirements
Module: disk_xfer_seq

Interface
REQ-001 Parameter BLOCK_WORDS, default 256, words per block; the sequencer counts exactly this many data strobes per block.
REQ-002 Parameter TIMEOUT, default 4096, cycles allowed per wait state before error.
REQ-003 Ports: clk  in  1  single clock, all logic on posedge; reset is asynchronous and active-high.
REQ-004 reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
REQ-005 start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 is_write  in  1  transfer direction, 1=write to disk, 0=read; sampled with start.
REQ-007 start_block  in  32  first block address; sampled with start.
REQ-008 block_count  in  16  number of blocks; sampled with start.
REQ-009 abort  in  1  level; stop after the block in progress.
REQ-010 wfifo_full_block  in  1  write FIFO holds >= BLOCK_WORDS words.
REQ-011 rfifo_room_block  in  1  read FIFO has >= BLOCK_WORDS free entries.
REQ-012 command_ready  in  1  disk accepts a command.
REQ-013 write_data_enable  in  1  disk word-pop strobe, write direction.
REQ-014 read_data_enable  in  1  disk word-push strobe, read direction.
REQ-015 read_cmd, write_cmd  out  1 each  disk command requests.
REQ-016 block_address  out  32  current block address to disk.
REQ-017 busy  out  1  high from start acceptance until done.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 error  out  1  latched fault flag, cleared by next accepted start.
REQ-020 aborted  out  1  latched, set when a transfer ended via abort; cleared by next accepted start.
REQ-021 blocks_done  out  16  count of fully transferred blocks in current transfer.

Function
REQ-022 States: IDLE, WAITBUF, ISSUE, XFER, FINISH; all registered outputs.
REQ-023 IDLE: on start, latch direction/address/count, clear blocks_done/error/aborted, set busy; go FINISH if block_count==0 (no commands issued), else WAITBUF.
REQ-024 WAITBUF: wait for wfifo_full_block (write) or rfifo_room_block (read); if abort high, go FINISH with aborted=1; else go ISSUE.
REQ-025 ISSUE: assert read_cmd or write_cmd (per direction) only while command_ready is high; hold it asserted until the first cycle command_ready is sampled low, then deassert the same cycle and go XFER.
REQ-026 XFER: count strobes of the active direction only (other-direction strobe sets error); at BLOCK_WORDS strobes and command_ready high, increment blocks_done and block_address (32-bit wrap, 0xFFFFFFFF -> 0).
REQ-027 After a block: if blocks_done==block_count or abort high, go FINISH (aborted=1 only if blocks remain); else WAITBUF.
REQ-028 A strobe beyond BLOCK_WORDS in one block sets error; the block still completes on command_ready.
REQ-029 Timeout counter resets on every state change and every strobe; reaching TIMEOUT in WAITBUF, ISSUE or XFER sets error, drops commands, goes FINISH.
REQ-030 FINISH: pulse done one cycle, clear busy the same cycle, return to IDLE; error/aborted/blocks_done hold until next start.
REQ-031 start while busy is ignored; strobes in IDLE are ignored.
REQ-032 Never both read_cmd and write_cmd high; no command when not in ISSUE.

Reset
REQ-033 On reset: state IDLE; read_cmd, write_cmd, busy, done, error, aborted = 0; block_address, blocks_done, counters = 0.
REQ-034 Reset mid-transfer takes effect asynchronously; no done pulse is produced for the killed transfer.

Verification
REQ-035 Write, start_block=5, count=1, FIFO ready, disk model gives 256 write_data_enable -> one write_cmd with block_address=5, blocks_done=1, done pulse, error=0.
REQ-036 Read, start_block=10, count=3 -> read_cmds at addresses 10,11,12 in order, 768 strobes counted, done once, blocks_done=3.
REQ-037 block_count=0 -> done within 3 cycles of start, no command asserted, blocks_done=0.
REQ-038 Count=4, abort raised during block 2 XFER -> block 2 completes, done with aborted=1, blocks_done=2, no third command.
REQ-039 command_ready held low in ISSUE for TIMEOUT cycles -> error=1, commands low, done pulse; start_block=0xFFFFFFFF count=2 -> addresses 0xFFFFFFFF then 0.
REQ-040 Reset asserted mid-XFER -> all outputs 0 immediately, no done pulse, next start operates normally.

Source files
------------

// File: rtl/disk_xfer_seq_if.sv
// Bundles the host, buffer and disk signals of the block transfer sequencer.
// master: the sequencer side. It drives the disk commands, the block address
//         and the status outputs, and receives requests and disk strobes.
// slave:  the environment side (host, FIFOs and disk). It drives start and
//         its parameters, abort, the FIFO levels, command_ready and the strobes.
interface disk_xfer_seq_if;
  logic        start;
  logic        is_write;
  logic [31:0] start_block;
  logic [15:0] block_count;
  logic        abort;
  logic        wfifo_full_block;
  logic        rfifo_room_block;
  logic        command_ready;
  logic        write_data_enable;
  logic        read_data_enable;
  logic        read_cmd;
  logic        write_cmd;
  logic [31:0] block_address;
  logic        busy;
  logic        done;
  logic        error;
  logic        aborted;
  logic [15:0] blocks_done;

  modport master (
    input  start, is_write, start_block, block_count, abort,
           wfifo_full_block, rfifo_room_block, command_ready,
           write_data_enable, read_data_enable,
    output read_cmd, write_cmd, block_address, busy, done, error,
           aborted, blocks_done
  );

  modport slave (
    output start, is_write, start_block, block_count, abort,
           wfifo_full_block, rfifo_room_block, command_ready,
           write_data_enable, read_data_enable,
    input  read_cmd, write_cmd, block_address, busy, done, error,
           aborted, blocks_done
  );
endinterface

// File: rtl/disk_xfer_seq.sv
// Multi-block disk transfer sequencer. For each block it waits for FIFO
// space or data, issues one read or write command, counts BLOCK_WORDS data
// strobes, and then advances the block address. The transfer can be aborted
// after the block in progress. Any wait state that lasts TIMEOUT cycles ends
// the transfer with error set.
// Ports:
//   clk   - single clock; all logic is on the rising edge.
//   reset - asynchronous, active-high; clears all state and outputs.
//   bus   - disk_xfer_seq_if.master; start/parameters, abort, FIFO levels,
//           disk handshake in; commands, address and status out.
module disk_xfer_seq #(
  parameter int BLOCK_WORDS = 256,
  parameter int TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             reset,
  disk_xfer_seq_if.master  bus
);

  localparam int WCNT_W = $clog2(BLOCK_WORDS + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WORDS_FULL = WCNT_W'(BLOCK_WORDS);
  localparam logic [TCNT_W-1:0] TOUT_LAST  = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAITBUF = 3'd1,
    ISSUE   = 3'd2,
    XFER    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t              state_r;
  logic                dir_r;      // 1 = write to disk
  logic [15:0]         count_r;
  logic [31:0]         addr_r;
  logic [15:0]         bdone_r;
  logic [WCNT_W-1:0]   wcnt_r;
  logic [TCNT_W-1:0]   tcnt_r;
  logic                issued_r;   // command has been seen with command_ready high
  logic                rd_r;
  logic                wr_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic                ab_r;

  logic                buf_ok_s;
  logic                act_strobe_s;
  logic                oth_strobe_s;
  logic                timeout_s;
  logic [15:0]         bdone_next_s;

  assign buf_ok_s     = dir_r ? bus.wfifo_full_block : bus.rfifo_room_block;
  assign act_strobe_s = dir_r ? bus.write_data_enable : bus.read_data_enable;
  assign oth_strobe_s = dir_r ? bus.read_data_enable : bus.write_data_enable;
  // This cycle is the TIMEOUT-th one spent in the current wait.
  assign timeout_s    = (tcnt_r == TOUT_LAST);
  assign bdone_next_s = bdone_r + 16'd1;

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      dir_r    <= 1'b0;
      count_r  <= 16'd0;
      addr_r   <= 32'd0;
      bdone_r  <= 16'd0;
      wcnt_r   <= '0;
      tcnt_r   <= '0;
      issued_r <= 1'b0;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ab_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          rd_r   <= 1'b0;
          wr_r   <= 1'b0;
          tcnt_r <= '0;
          if (bus.start) begin
            dir_r    <= bus.is_write;
            addr_r   <= bus.start_block;
            count_r  <= bus.block_count;
            bdone_r  <= 16'd0;
            err_r    <= 1'b0;
            ab_r     <= 1'b0;
            busy_r   <= 1'b1;
            wcnt_r   <= '0;
            issued_r <= 1'b0;
            state_r  <= (bus.block_count == 16'd0) ? FINISH : WAITBUF;
          end
        end

        WAITBUF: begin
          rd_r <= 1'b0;
          wr_r <= 1'b0;
          if (bus.abort) begin
            ab_r    <= 1'b1;
            tcnt_r  <= '0;
            state_r <= FINISH;
          end else if (buf_ok_s) begin
            issued_r <= 1'b0;
            tcnt_r   <= '0;
            state_r  <= ISSUE;
          end else if (timeout_s) begin
            err_r   <= 1'b1;
            tcnt_r  <= '0;
            state_r <= FINISH;
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end
        end

        ISSUE: begin
          // The command follows command_ready until the disk takes it, which
          // is signalled by command_ready falling after the command was seen.
          if (bus.command_ready) begin
            rd_r     <= ~dir_r;
            wr_r     <= dir_r;
            issued_r <= 1'b1;
          end
          if (!bus.command_ready && issued_r) begin
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            wcnt_r  <= '0;
            tcnt_r  <= '0;
            state_r <= XFER;
          end else if (timeout_s) begin
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            err_r   <= 1'b1;
            tcnt_r  <= '0;
            state_r <= FINISH;
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end
        end

        XFER: begin
          rd_r <= 1'b0;
          wr_r <= 1'b0;
          if (oth_strobe_s) begin
            err_r <= 1'b1;
          end
          if (act_strobe_s) begin
            if (wcnt_r == WORDS_FULL) begin
              err_r <= 1'b1;  // overrun; the count saturates
            end else begin
              wcnt_r <= wcnt_r + WCNT_W'(1);
            end
          end
          if ((wcnt_r == WORDS_FULL) && bus.command_ready) begin
            bdone_r <= bdone_next_s;
            addr_r  <= addr_r + 32'd1;
            wcnt_r  <= '0;
            tcnt_r  <= '0;
            if (bdone_next_s == count_r) begin
              state_r <= FINISH;
            end else if (bus.abort) begin
              ab_r    <= 1'b1;
              state_r <= FINISH;
            end else begin
              state_r <= WAITBUF;
            end
          end else if (act_strobe_s) begin
            tcnt_r <= '0;
          end else if (timeout_s) begin
            err_r   <= 1'b1;
            tcnt_r  <= '0;
            state_r <= FINISH;
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end
        end

        FINISH: begin
          rd_r    <= 1'b0;
          wr_r    <= 1'b0;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          tcnt_r  <= '0;
          state_r <= IDLE;
        end

        default: begin
          rd_r    <= 1'b0;
          wr_r    <= 1'b0;
          busy_r  <= 1'b0;
          tcnt_r  <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.read_cmd      = rd_r;
  assign bus.write_cmd     = wr_r;
  assign bus.block_address = addr_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.error         = err_r;
  assign bus.aborted       = ab_r;
  assign bus.blocks_done   = bdone_r;

endmodule

// File: tb/tb_disk_xfer_seq.sv
// Scoreboard testbench for disk_xfer_seq. The stimulus pushes the expected
// commands and completions into queues. A negedge monitor pops and compares
// them whenever a command rises or done pulses. A behavioural disk answers
// each command with a burst of data strobes.
module tb_disk_xfer_seq;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
  } cmd_t;

  typedef struct packed {
    logic        err;
    logic        ab;
    logic [15:0] bd;
  } fin_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  disk_xfer_seq_if bus();

  disk_xfer_seq #(.BLOCK_WORDS(256), .TIMEOUT(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cmd_t exp_cmd_q[$];
  fin_t exp_fin_q[$];

  int checks       = 0;
  int errors       = 0;
  int cmd_count    = 0;
  int done_count   = 0;
  int strobe_total = 0;
  int disk_words   = 256;
  bit disk_on      = 1'b1;
  bit disk_busy    = 1'b0;
  bit disk_dir     = 1'b0;
  bit cmd_prev     = 1'b0;
  bit cmd_now;
  cmd_t  got_cmd, exp_c;
  fin_t  exp_f;
  logic [20:0] got_fin;

  // Monitor: compares the command order and the completion status against the queues.
  always @(negedge clk) begin
    if (reset) begin
      cmd_prev = 1'b0;
    end else begin
      cmd_now = bus.read_cmd | bus.write_cmd;
      if (cmd_now) begin
        checks++;
        if (bus.read_cmd && bus.write_cmd) begin
          errors++;
          $display("FAIL cmd_exclusive: read_cmd=1 write_cmd=1, required at most one high");
        end
      end
      if (cmd_now && !cmd_prev) begin
        checks++;
        got_cmd = {bus.write_cmd, bus.block_address};
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got wr=%0b addr=%h, required no command", got_cmd.wr, got_cmd.addr);
        end else begin
          exp_c = exp_cmd_q.pop_front();
          if (got_cmd !== exp_c) begin
            errors++;
            $display("FAIL cmd_order: got wr=%0b addr=%h, required wr=%0b addr=%h",
                     got_cmd.wr, got_cmd.addr, exp_c.wr, exp_c.addr);
          end
        end
        cmd_count++;
      end
      cmd_prev = cmd_now;
      if (bus.done) begin
        checks++;
        got_fin = {bus.busy, bus.read_cmd, bus.write_cmd, bus.error, bus.aborted, bus.blocks_done};
        if (exp_fin_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got busy/rd/wr/err/ab/bd=%h, required no done", got_fin);
        end else begin
          exp_f = exp_fin_q.pop_front();
          if (got_fin !== {3'b000, exp_f}) begin
            errors++;
            $display("FAIL done_status: got busy/rd/wr/err/ab/bd=%h, required %h", got_fin, {3'b000, exp_f});
          end
        end
        done_count++;
      end
    end
  end

  // Disk model: takes each command, drops command_ready and streams disk_words strobes.
  always begin
    @(negedge clk);
    if (disk_on && !reset && (bus.read_cmd || bus.write_cmd)) begin
      disk_busy = 1'b1;
      disk_dir  = bus.write_cmd;
      @(negedge clk);
      bus.command_ready = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < disk_words; i++) begin
        if (disk_dir) bus.write_data_enable = 1'b1;
        else          bus.read_data_enable  = 1'b1;
        @(negedge clk);
        bus.write_data_enable = 1'b0;
        bus.read_data_enable  = 1'b0;
        strobe_total++;
        if ((i % 16) == 5) @(negedge clk);
      end
      bus.command_ready = 1'b1;
      disk_busy = 1'b0;
    end
  end

  task automatic push_cmd(input logic wr, input logic [31:0] addr);
    exp_cmd_q.push_back({wr, addr});
  endtask

  task automatic push_fin(input logic err, input logic ab, input logic [15:0] bd);
    exp_fin_q.push_back({err, ab, bd});
  endtask

  task automatic start_xfer(input logic wr, input logic [31:0] sb, input logic [15:0] cnt);
    bus.is_write    = wr;
    bus.start_block = sb;
    bus.block_count = cnt;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    int n;
    base = done_count;
    n = 0;
    while (done_count == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_count == base) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles, required a done pulse", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // Waits until the target command has been accepted and the block is streaming.
  task automatic wait_in_xfer(input string name, input int target);
    int n;
    n = 0;
    while (!(cmd_count >= target && bus.command_ready == 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s: commands seen %0d, required %0d and a block in progress", name, cmd_count, target);
    end
  endtask

  task automatic check_idle(input string name);
    logic [85:0] got;
    got = {bus.read_cmd, bus.write_cmd, bus.busy, bus.done, bus.error, bus.aborted,
           bus.block_address, bus.blocks_done, 32'd0};
    checks++;
    if (got !== 86'd0) begin
      errors++;
      $display("FAIL %s: rd=%0b wr=%0b busy=%0b done=%0b err=%0b ab=%0b addr=%h bd=%0d, required all zero",
               name, bus.read_cmd, bus.write_cmd, bus.busy, bus.done, bus.error, bus.aborted,
               bus.block_address, bus.blocks_done);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit seen;
    reset                 = 1'b1;
    bus.start             = 1'b0;
    bus.is_write          = 1'b0;
    bus.start_block       = 32'd0;
    bus.block_count       = 16'd0;
    bus.abort             = 1'b0;
    bus.wfifo_full_block  = 1'b1;
    bus.rfifo_room_block  = 1'b1;
    bus.command_ready     = 1'b1;
    bus.write_data_enable = 1'b0;
    bus.read_data_enable  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single write block at address 5.
    push_cmd(1'b1, 32'd5);
    push_fin(1'b0, 1'b0, 16'd1);
    start_xfer(1'b1, 32'd5, 16'd1);
    wait_done("write_one_block", 3000);

    // Three read blocks from address 10.
    strobe_total = 0;
    push_cmd(1'b0, 32'd10);
    push_cmd(1'b0, 32'd11);
    push_cmd(1'b0, 32'd12);
    push_fin(1'b0, 1'b0, 16'd3);
    start_xfer(1'b0, 32'd10, 16'd3);
    wait_done("read_three_blocks", 6000);
    checks++;
    if (strobe_total != 768) begin
      errors++;
      $display("FAIL read_strobe_total: got %0d, required 768", strobe_total);
    end

    // Zero block count completes quickly with no command.
    push_fin(1'b0, 1'b0, 16'd0);
    start_xfer(1'b0, 32'd77, 16'd0);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL zero_count_latency: done not seen within 3 cycles, required done");
    end
    repeat (3) @(negedge clk);

    // Abort raised during the second block of four.
    base = cmd_count;
    push_cmd(1'b1, 32'd100);
    push_cmd(1'b1, 32'd101);
    push_fin(1'b0, 1'b1, 16'd2);
    start_xfer(1'b1, 32'd100, 16'd4);
    wait_in_xfer("abort_reach_block2", base + 2);
    bus.abort = 1'b1;
    wait_done("abort_mid_block2", 3000);
    bus.abort = 1'b0;

    // Disk never ready for the command: timeout.
    disk_on = 1'b0;
    bus.command_ready = 1'b0;
    push_fin(1'b1, 1'b0, 16'd0);
    start_xfer(1'b1, 32'd200, 16'd1);
    wait_done("issue_timeout", 5000);
    bus.command_ready = 1'b1;
    disk_on = 1'b1;
    repeat (2) @(negedge clk);

    // Address wraps from all-ones to zero.
    push_cmd(1'b0, 32'hFFFF_FFFF);
    push_cmd(1'b0, 32'h0000_0000);
    push_fin(1'b0, 1'b0, 16'd2);
    start_xfer(1'b0, 32'hFFFF_FFFF, 16'd2);
    wait_done("address_wrap", 5000);

    // One strobe too many flags an error but the block still completes.
    disk_words = 257;
    push_cmd(1'b0, 32'd300);
    push_fin(1'b1, 1'b0, 16'd1);
    start_xfer(1'b0, 32'd300, 16'd1);
    wait_done("strobe_overrun", 3000);
    disk_words = 256;

    // Reset in the middle of a block kills the transfer without a done pulse.
    base = cmd_count;
    push_cmd(1'b1, 32'd400);
    start_xfer(1'b1, 32'd400, 16'd2);
    wait_in_xfer("reset_reach_xfer", base + 1);
    repeat (20) @(negedge clk);
    base = done_count;
    #2 reset = 1'b1;
    #1 check_idle("reset_mid_xfer");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (disk_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_count != base) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses, required 0", done_count - base);
    end

    // Normal operation after the reset.
    push_cmd(1'b0, 32'd500);
    push_fin(1'b0, 1'b0, 16'd1);
    start_xfer(1'b0, 32'd500, 16'd1);
    wait_done("after_reset", 3000);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_cmd_q.size() != 0) begin
      errors++;
      $display("FAIL cmd_queue_drain: %0d commands left, required 0", exp_cmd_q.size());
    end
    checks++;
    if (exp_fin_q.size() != 0) begin
      errors++;
      $display("FAIL done_queue_drain: %0d completions left, required 0", exp_fin_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
